// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory port, decode handshake, redirect/halt control.
// The fetch unit takes the master side; memory, decode and execute take the slave side.
interface inst_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [4:0]  opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic        misaligned;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst_data, inst_pc, opcode,
        input  inst_ready,
        input  redirect_valid, redirect_pc, halt,
        output halted, misaligned
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst_data, inst_pc, opcode,
        output inst_ready,
        output redirect_valid, redirect_pc, halt,
        input  halted, misaligned
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: single-outstanding imem requests, DEPTH-entry instruction FIFO, redirect/halt.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect target sets sticky misaligned and halts.
module inst_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_unit_if.master bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALTED} state_t;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n, req_pc;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_n;
    logic          drop, drop_n, mis, mis_n;
    logic          grant, push, pop, flush, redir, halt_in, bad_tgt;
    logic [31:0]   tgt;

    // Once halted, only reset brings the unit back; late control pulses are ignored.
    assign redir   = bus.redirect_valid & (state != HALTED);
    assign halt_in = bus.halt & (state != HALTED);
    assign flush   = redir | halt_in;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt     = bus.redirect_pc;
    assign bad_tgt = redir & (bus.redirect_pc[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign unused_lsb = ^bus.redirect_pc[1:0];
    assign tgt        = {bus.redirect_pc[31:2], 2'b00};
    assign bad_tgt    = 1'b0;
`endif

    assign grant = (state == REQ) & bus.imem_gnt;
    assign push  = (state == WAIT) & bus.imem_rvalid & ~drop & ~flush;
    assign pop   = bus.inst_valid & bus.inst_ready & ~flush;

    always_comb begin
        count_n = count;
        if (flush) count_n = '0;
        else       count_n = count + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        mis_n   = mis;
        case (state)
            IDLE:    if (count_n < FULL) state_n = REQ;
            REQ:     if (grant) begin
                         state_n = WAIT;
                         pc_n    = pc + 32'd4;
                     end
            WAIT:    if (bus.imem_rvalid) begin
                         drop_n  = 1'b0;
                         state_n = (count_n < FULL) ? REQ : IDLE;
                     end
            default: ;
        endcase
        // A response already in flight belongs to the old stream and must be discarded.
        if (redir) begin
            pc_n = tgt;
            if (grant)                                      drop_n  = 1'b1;
            else if (state == REQ)                          state_n = IDLE;
            else if (state == WAIT && !bus.imem_rvalid)     drop_n  = 1'b1;
        end
        if (bad_tgt) begin
            mis_n   = 1'b1;
            state_n = HALTED;
        end
        if (halt_in) state_n = HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            drop   <= 1'b0;
            mis    <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            drop  <= drop_n;
            mis   <= mis_n;
            count <= count_n;
            if (grant) req_pc <= pc;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr] <= bus.imem_rdata;
            fifo_pc[wptr]   <= req_pc;
        end
    end

    assign bus.imem_req   = (state == REQ);
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = bus.inst_valid ? fifo_data[rptr] : 32'h0;
    assign bus.inst_pc    = bus.inst_valid ? fifo_pc[rptr]   : 32'h0;
    assign bus.opcode     = bus.inst_data[6:2];
    assign bus.halted     = (state == HALTED);
    assign bus.misaligned = mis;
endmodule
